ides4_bitslip_align: RTL and testbench

Read-path word-alignment controller for the 4:1 input deserialiser (IDES4) in the DDR3 PHY. It samples the deserialised 4-bit word on the slow clock and compares it with a known training pattern. On mismatch it issues CALIB pulses to the deserialiser, one bit-slip per pulse, until the word matches for a required number of consecutive cycles. It then reports lock, or failure after a bounded number of slips. It sits between the IDES4 Q outputs and the DDR3 read-training sequencer, on the same clock as the deserialiser PCLK.

---
 rtl/ides4_bitslip_align.sv | 179 +++++++++++++++++
 tb/tb_ides4_bitslip_align.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ides4_bitslip_align.sv
// IDES4 read-path word aligner: compares the deserialised word with a training
// pattern and bit-slips the deserialiser via CALIB until the word holds steady.
module ides4_bitslip_align #(
  parameter logic [3:0]  PATTERN     = 4'b1100,
  parameter int unsigned CALIB_HOLD  = 8,
  parameter int unsigned MATCH_COUNT = 16,
  parameter int unsigned MAX_SLIPS   = 7,
  parameter int unsigned LOSS_COUNT  = 4
) (
  input  logic       CLK,
  input  logic       grstn,
  input  logic       start_i,
  input  logic [3:0] data_i,
  output logic       calib_o,
  output logic       busy_o,
  output logic       locked_o,
  output logic       failed_o,
  output logic       lost_o,
  output logic [3:0] slips_o
);

  localparam logic [7:0] HOLD_INIT  = 8'(CALIB_HOLD);
  localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
  localparam logic [3:0] SLIPS_MAX  = 4'(MAX_SLIPS);
  localparam logic [3:0] LOSS_LAST  = 4'(LOSS_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] match_q, match_d;
  logic [3:0] loss_q, loss_d;
  logic [3:0] slips_d;
  logic       phase_q, phase_d;
  logic       start_q;
  logic       calib_d, busy_d, locked_d, failed_d, lost_d;
  logic       word_ok;
  logic       restart;

  assign word_ok = (data_i == PATTERN);

  // A registered start is only honoured where training may (re)begin.
  assign restart = start_q &&
                   ((state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_FAIL));

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    match_d  = match_q;
    loss_d   = loss_q;
    phase_d  = phase_q;
    slips_d  = slips_o;
    calib_d  = 1'b0;
    busy_d   = busy_o;
    locked_d = locked_o;
    failed_d = failed_o;
    lost_d   = 1'b0;

    case (state_q)
      S_IDLE: ;

      S_WAIT: begin
        if (hold_q == 8'd1) begin
          state_d = S_CHECK;
          match_d = 8'd0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end

      S_CHECK: begin
        if (word_ok) begin
          if (match_q == MATCH_LAST) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            busy_d   = 1'b0;
            loss_d   = 4'd0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end else if (slips_o == SLIPS_MAX) begin
          state_d  = S_FAIL;
          failed_d = 1'b1;
          busy_d   = 1'b0;
        end else begin
          state_d = S_SLIP;
          slips_d = slips_o + 4'd1;
          calib_d = 1'b1;
          phase_d = 1'b0;
        end
      end

      // CALIB is held for two PCLK cycles so the 2x FCLK synchroniser in IDES4
      // is guaranteed to see the rising edge.
      S_SLIP: begin
        if (!phase_q) begin
          calib_d = 1'b1;
          phase_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          hold_d  = HOLD_INIT;
        end
      end

      S_LOCKED: begin
        if (word_ok) begin
          loss_d = 4'd0;
        end else if (loss_q == LOSS_LAST) begin
          state_d  = S_IDLE;
          lost_d   = 1'b1;
          locked_d = 1'b0;
          loss_d   = 4'd0;
        end else begin
          loss_d = loss_q + 4'd1;
        end
      end

      S_FAIL: ;

      default: state_d = S_IDLE;
    endcase

    // Restart overrides LOCKED loss tracking, so no lost pulse on a retrain.
    if (restart) begin
      state_d  = S_WAIT;
      hold_d   = HOLD_INIT;
      match_d  = 8'd0;
      loss_d   = 4'd0;
      phase_d  = 1'b0;
      slips_d  = 4'd0;
      busy_d   = 1'b1;
      locked_d = 1'b0;
      failed_d = 1'b0;
      lost_d   = 1'b0;
      calib_d  = 1'b0;
    end
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge CLK or negedge grstn) begin
    if (!grstn) begin
      state_q  <= S_IDLE;
      hold_q   <= 8'd0;
      match_q  <= 8'd0;
      loss_q   <= 4'd0;
      phase_q  <= 1'b0;
      start_q  <= 1'b0;
      slips_o  <= 4'd0;
      calib_o  <= 1'b0;
      busy_o   <= 1'b0;
      locked_o <= 1'b0;
      failed_o <= 1'b0;
      lost_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      phase_q  <= phase_d;
      start_q  <= start_i;
      slips_o  <= slips_d;
      calib_o  <= calib_d;
      busy_o   <= busy_d;
      locked_o <= locked_d;
      failed_o <= failed_d;
      lost_o   <= lost_d;
    end
  end

endmodule

// File: tb/tb_ides4_bitslip_align.sv
// Randomised bench for ides4_bitslip_align: a behavioural IDES4 model slips on
// each CALIB pulse; a timeline model predicts outcomes into a scoreboard queue.
module tb_ides4_bitslip_align;

  localparam logic [3:0] PAT = 4'b1100;
  localparam int H  = 8;
  localparam int M  = 16;
  localparam int MS = 7;
  localparam int LC = 4;

  logic       CLK = 1'b0;
  logic       grstn;
  logic       start_i;
  logic [3:0] data_i;
  logic       calib_o, busy_o, locked_o, failed_o, lost_o;
  logic [3:0] slips_o;

  ides4_bitslip_align #(
    .PATTERN(PAT), .CALIB_HOLD(H), .MATCH_COUNT(M), .MAX_SLIPS(MS), .LOSS_COUNT(LC)
  ) dut (
    .CLK(CLK), .grstn(grstn), .start_i(start_i), .data_i(data_i),
    .calib_o(calib_o), .busy_o(busy_o), .locked_o(locked_o), .failed_o(failed_o),
    .lost_o(lost_o), .slips_o(slips_o)
  );

  always #5 CLK = ~CLK;

  typedef enum int {EV_LOCK, EV_FAIL, EV_LOST} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       rel;
    int       slips;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   start_edge = 0;

  // Deserialiser model state
  int         offset   = 0;
  bit         stuck    = 1'b0;
  int         bad_rel  = -1;
  logic       calib_prev = 1'b0;
  logic [3:0] forced_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
    logic [3:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  // Timeline of one training: CHECK opens at 1+H; each good word extends the
  // run; each bad word costs a slip (2 CALIB cycles + H wait) or ends in failure.
  function automatic exp_t predict(input int off, input bit stk, input int bad);
    exp_t e;
    int   t;
    int   run;
    int   slips;
    bit   ok;
    t = 1 + H; run = 0; slips = 0;
    e.kind = EV_FAIL; e.rel = -1; e.slips = 0;
    for (int guard = 0; guard < 10000; guard++) begin
      t++;
      ok = !stk && (off == 0) && (t != bad);
      if (ok) begin
        run++;
        if (run == M) begin
          e.kind = EV_LOCK; e.rel = t; e.slips = slips;
          return e;
        end
      end else if (slips == MS) begin
        e.kind = EV_FAIL; e.rel = t; e.slips = slips;
        return e;
      end else begin
        slips++;
        off = (off + 3) % 4;
        run = 0;
        t += 2 + H;
      end
    end
    return e;
  endfunction

  // Drive the word the DUT will sample on the next rising edge.
  task automatic drive_word();
    int nxt;
    nxt = cyc + 1 - start_edge;
    if (calib_prev && !calib_o) offset = (offset + 3) % 4;
    calib_prev = calib_o;
    if (forced_q.size() > 0)  data_i = forced_q.pop_front();
    else if (stuck)           data_i = 4'b0000;
    else if (nxt == bad_rel)  data_i = PAT ^ 4'($urandom_range(1, 15));
    else                      data_i = rotl(PAT, offset);
  endtask

  task automatic tick();
    @(negedge CLK);
    drive_word();
  endtask

  task automatic run_training(input int off, input bit stk, input int bad,
                              input bit poke_en, input bit probe, output exp_t e);
    int poke;
    bit done;
    e = predict(off, stk, bad);
    sb.push_back(e);
    poke = poke_en ? $urandom_range(2, e.rel - 3) : -1;
    @(negedge CLK);
    offset = off; stuck = stk; bad_rel = bad; forced_q.delete();
    start_edge = cyc + 1;
    start_i = 1'b1;
    drive_word();
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      start_i = ((cyc + 1 - start_edge) == poke);
      if (probe && ((cyc - start_edge) == bad)) begin
        check("late_mismatch_slips", int'(slips_o), 1);
        check("late_mismatch_calib", int'(calib_o), 1);
        check("late_mismatch_nolock", int'(locked_o), 0);
      end
      if ((cyc - start_edge) >= 1 && !busy_o && (locked_o || failed_o)) begin
        done = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    check("training_done", int'(done), 1);
  endtask

  task automatic run_loss(input bit fixed, input int slips_exp, input int rel_lock);
    bit bads[$];
    int run;
    int j;
    bit seen;
    if (fixed) begin
      bads = '{1, 1, 1, 0, 1, 1, 1, 1};
    end else begin
      for (int i = 0; i < $urandom_range(2, 10); i++) bads.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < LC; i++) bads.push_back(1'b1);
    end
    run = 0; j = -1;
    foreach (bads[i]) begin
      run = bads[i] ? run + 1 : 0;
      if (run == LC && j < 0) j = i;
    end
    forced_q.delete();
    foreach (bads[i]) forced_q.push_back(bads[i] ? (PAT ^ 4'($urandom_range(1, 15))) : PAT);
    // The word for edge rel_lock+1 is already driven; forced words start after it.
    sb.push_back('{EV_LOST, rel_lock + 2 + j, slips_exp});
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (lost_o) begin
        seen = 1'b1;
        break;
      end
    end
    forced_q.delete();
    check("loss_seen", int'(seen), 1);
  endtask

  // Monitor: observes outputs, checks pulse shapes and pops the scoreboard.
  logic     busy_p, calib_p, locked_p, failed_p, lost_p;
  int       hi_len, lo_len, pulses, mrel;
  exp_t     me;
  ev_kind_t mk;

  initial begin
    busy_p = 0; calib_p = 0; locked_p = 0; failed_p = 0; lost_p = 0;
    hi_len = 0; lo_len = 0; pulses = 0;
    forever begin
      @(negedge CLK);
      if (!grstn) begin
        busy_p = 0; calib_p = 0; locked_p = 0; failed_p = 0; lost_p = 0;
        hi_len = 0; lo_len = 0;
      end else begin
        mrel = cyc - start_edge;
        if (busy_o && !busy_p) begin
          check("busy_rise_edge", mrel, 1);
          check("restart_clears", int'({locked_o, failed_o, slips_o}), 0);
          pulses = 0;
        end
        if (calib_o) begin
          if (!calib_p) begin
            if (pulses > 0) check("calib_gap_ok", int'(lo_len >= H + 1), 1);
            pulses++;
            hi_len = 0;
          end
          hi_len++;
          lo_len = 0;
          check("calib_only_training", int'(busy_o && !locked_o && !failed_o), 1);
        end else begin
          if (calib_p) check("calib_width", hi_len, 2);
          lo_len++;
        end
        if (locked_o || failed_o) check("lock_fail_exclusive", int'(locked_o && failed_o), 0);
        if (lost_o && lost_p) check("lost_single_cycle", 2, 1);
        if ((locked_o && !locked_p) || (failed_o && !failed_p) || (lost_o && !lost_p)) begin
          mk = lost_o ? EV_LOST : (locked_o ? EV_LOCK : EV_FAIL);
          if (sb.size() == 0) begin
            check("event_expected", 0, 1);
          end else begin
            me = sb.pop_front();
            check("event_kind", int'(mk), int'(me.kind));
            check("event_edge", mrel, me.rel);
            check("event_slips", int'(slips_o), me.slips);
            check("event_busy_low", int'(busy_o), 0);
            if (mk == EV_LOST) check("loss_unlocked", int'(locked_o), 0);
            else               check("calib_pulses", pulses, me.slips);
          end
        end
        busy_p = busy_o; calib_p = calib_o; locked_p = locked_o;
        failed_p = failed_o; lost_p = lost_o;
      end
    end
  end

  initial begin
    exp_t e;
    int   off;
    int   bad;
    bit   found;

    grstn = 1'b0; start_i = 1'b0; data_i = 4'b0000;
    repeat (3) @(negedge CLK);
    check("reset_outputs", int'({calib_o, busy_o, locked_o, failed_o, lost_o, slips_o}), 0);
    grstn = 1'b1;
    repeat (3) tick();
    check("idle_without_start", int'({calib_o, busy_o}), 0);

    run_training(0, 1'b0, -1, 1'b1, 1'b0, e);   // aligned
    run_loss(1'b1, e.slips, e.rel);              // 3 bad, 1 good, 4 bad
    run_training(2, 1'b0, -1, 1'b1, 1'b0, e);   // two slips
    run_training(0, 1'b1, -1, 1'b0, 1'b0, e);   // never aligns
    run_training(0, 1'b0, M + H + 1, 1'b0, 1'b1, e);  // late mismatch, restart from FAIL

    for (int r = 0; r < 8; r++) begin
      off = $urandom_range(0, 3);
      bad = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 1 + H + M) : -1;
      run_training(off, 1'b0, bad, 1'($urandom_range(0, 1)), 1'b0, e);
      if (e.kind == EV_LOCK && $urandom_range(0, 1) == 1) run_loss(1'b0, e.slips, e.rel);
    end
    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 0);

    // Reset during the second CALIB cycle of the second slip.
    @(negedge CLK);
    offset = 2; stuck = 1'b0; bad_rel = -1; forced_q.delete();
    start_edge = cyc + 1;
    start_i = 1'b1;
    drive_word();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      start_i = ((cyc + 1 - start_edge) == 5);
      if (calib_o && slips_o == 4'd2) begin
        found = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    check("reached_second_pulse", int'(found), 1);
    tick();
    check("calib_second_cycle", int'(calib_o), 1);
    #2 grstn = 1'b0;
    #1;
    check("async_reset_outputs", int'({calib_o, busy_o, locked_o, failed_o, lost_o, slips_o}), 0);
    repeat (3) tick();
    @(negedge CLK);
    grstn = 1'b1;
    repeat (20) tick();
    check("no_retrain_after_reset", int'({calib_o, busy_o, slips_o}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
